rotation_angle_gen: RTL and testbench
=====================================

Name: rotation_angle_gen

Overview:
- Upstream feeder for the sin/cos evaluation stage of the transform pipeline.
- Holds the three per-axis rotation angles (X, Y, Z) as unsigned 4.8 fixed point in [0, 2pi).
- On each frame start, advances every angle by a signed per-axis step and wraps the result modulo 2pi.
- Presents the three angles one at a time over a valid/ready handshake, so the trig stage always receives a range-reduced angle.

Parameters:
- WII, 4, integer bits of angle.
- WIF, 8, fractional bits of angle.
- AW, WII+WIF (12), angle width; derived, not overridden.
- TWO_PI, 12'h648, 2pi in 4.8; wrap modulus.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- frame_start  in  1  one-cycle pulse requesting a new angle update and send.
- freeze  in  1  sampled with frame_start; 1 = send angles without updating them.
- clear  in  1  synchronous; in IDLE, zeroes all three angles and clears the error flags.
- step_x, step_y, step_z  in  AW each  signed two's-complement 4.8 step per frame.
- angle_out  out  AW  angle presented to the trig stage, unsigned 4.8.
- axis_id  out  2  axis of angle_out: 0=X, 1=Y, 2=Z.
- angle_valid  out  1  angle_out and axis_id are valid.
- angle_ready  in  1  downstream accepts.
- frame_done  out  1  one-cycle pulse after the Z angle is transferred.
- busy  out  1  high in every state except IDLE.
- overrun  out  1  sticky; frame_start arrived while busy.
- step_err  out  1  sticky; a step with |step| >= TWO_PI was sampled.

Behaviour:
- Reset (async, Reset_n=0) forces:
  - state IDLE;
  - all angle registers = 0;
  - angle_out=0, axis_id=0;
  - angle_valid, frame_done, busy, overrun, step_err = 0.
- Reset asserted mid-send aborts the frame; no frame_done is produced.
- States and transitions:
  - IDLE -> UPDATE on frame_start.
  - UPDATE -> SEND_X after 1 cycle.
  - SEND_X -> SEND_Y -> SEND_Z, advancing on each transfer (angle_valid & angle_ready).
  - SEND_Z -> DONE on transfer.
  - DONE -> IDLE after 1 cycle.
- Sampling: the step inputs and freeze are registered on the frame_start cycle.
- UPDATE arithmetic, all three axes in parallel:
  - sum = {1'b0, angle} + sign-extended step, computed at AW+1 bits.
  - If sum < 0: angle = sum + TWO_PI.
  - Else if sum >= TWO_PI: angle = sum - TWO_PI.
  - Else: angle = sum.
  - Stored angles therefore always lie in [0x000, 0x647].
- Step magnitude:
  - A step with |step| >= TWO_PI, including 12'h800, is treated as 0 for that axis and sets step_err.
  - A single correction is therefore always sufficient.
- freeze=1: UPDATE leaves the angles unchanged; the send sequence still runs.
- Latency: frame_start at cycle 0 -> UPDATE at cycle 1 -> angle_valid=1 with axis_id=0 at cycle 2.
- Minimum frame length with angle_ready held high: 6 cycles from frame_start to return to IDLE.
- Handshake:
  - angle_valid is high only in the SEND_* states.
  - angle_out and axis_id stay stable while angle_valid & !angle_ready.
  - angle_valid never drops without a transfer (except on reset).
  - angle_ready is don't-care while angle_valid=0.
- frame_done is high only in the DONE state.
- frame_start outside IDLE, including the DONE cycle, is ignored and sets overrun.
- clear:
  - Acts only in IDLE; ignored elsewhere.
  - clear and frame_start together in IDLE: clear wins, frame_start is ignored and no flag is set.
- Sticky flags reset only by Reset_n or clear.

Decomposition:
- Package rot_pkg holds:
  - typedef angle_t (logic [11:0]);
  - localparams TWO_PI=12'h648, PI=12'h324, HALF_PI=12'h192, THREE_HALF_PI=12'h4b6;
  - enum state_t {IDLE, UPDATE, SEND_X, SEND_Y, SEND_Z, DONE}.
- Sub-module angle_wrap_add: combinational (angle, step) -> (wrapped angle, step_bad).
- The top level instantiates angle_wrap_add three times.

Test Plan:
- Basic: reset, steps 0x010/0x020/0x030, one frame_start, ready=1 -> transfers 0x010, 0x020, 0x030 on axis 0/1/2 in cycles 2/3/4; frame_done in cycle 5.
- Positive wrap: X preloaded to 0x640 via 100 frames of 0x010 (0x640=1600=100*16), then step 0x010 -> X=0x008.
- Negative wrap: from 0, step_y=12'hFF0 (-0x010) -> Y=0x638. Bad step 12'h700 -> axis unchanged, step_err=1.
- Backpressure: ready low 3 cycles during SEND_Y -> angle_out/axis_id held constant, valid high; Z follows one cycle after ready rises.
- Overrun and freeze: frame_start during SEND_X -> overrun=1 and frame unaffected. freeze=1 frame -> the same three angles are resent.
- Reset mid-op: Reset_n low during SEND_Y -> all outputs 0 immediately; after release, the next frame from step 0x010 yields 0x010.

Source files
------------

// File: rtl/rot_pkg.sv
// Shared types and constants for the rotation angle generator.
// Angles are unsigned 4.8 fixed point; steps reuse the same width as signed values.
package rot_pkg;

    localparam int WII = 4;
    localparam int WIF = 8;
    localparam int AW  = WII + WIF;

    typedef logic [AW-1:0] angle_t;

    localparam angle_t TWO_PI        = 12'h648;
    localparam angle_t PI            = 12'h324;
    localparam angle_t HALF_PI       = 12'h192;
    localparam angle_t THREE_HALF_PI = 12'h4b6;

    localparam logic [1:0] AXIS_X = 2'd0;
    localparam logic [1:0] AXIS_Y = 2'd1;
    localparam logic [1:0] AXIS_Z = 2'd2;

    typedef enum logic [2:0] {
        IDLE,
        UPDATE,
        SEND_X,
        SEND_Y,
        SEND_Z,
        DONE
    } state_t;

endpackage

// File: rtl/angle_wrap_add.sv
// Adds a signed step to an angle in [0, 2pi) and folds the result back into range.
// Steps of magnitude >= 2pi are rejected (treated as zero) so one correction always suffices.
module angle_wrap_add
    import rot_pkg::*;
(
    input  angle_t angle,
    input  angle_t step,
    output angle_t wrapped,
    output logic   step_bad
);

    logic signed [AW:0] two_pi_ext;
    logic signed [AW:0] step_ext;
    logic signed [AW:0] step_eff;
    logic signed [AW:0] sum;
    logic signed [AW:0] folded;

    // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
    always_comb begin
        two_pi_ext = $signed({1'b0, TWO_PI});
        step_ext   = $signed({step[AW-1], step});
        step_bad   = (step_ext >= two_pi_ext) || (step_ext <= -two_pi_ext);
        step_eff   = step_bad ? '0 : step_ext;
        sum        = $signed({1'b0, angle}) + step_eff;
        if (sum < 0) begin
            folded = sum + two_pi_ext;
        end else if (sum >= two_pi_ext) begin
            folded = sum - two_pi_ext;
        end else begin
            folded = sum;
        end
        wrapped = folded[AW-1:0];
    end

endmodule

// File: rtl/rotation_angle_gen.sv
// Per-axis rotation angle accumulator feeding the sin/cos stage.
// On frame_start the X/Y/Z angles are advanced (unless frozen) and sent one by one over valid/ready.
module rotation_angle_gen
    import rot_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_start,
    input  logic       freeze,
    input  logic       clear,
    input  angle_t     step_x,
    input  angle_t     step_y,
    input  angle_t     step_z,
    output angle_t     angle_out,
    output logic [1:0] axis_id,
    output logic       angle_valid,
    input  logic       angle_ready,
    output logic       frame_done,
    output logic       busy,
    output logic       overrun,
    output logic       step_err
);

    state_t state;
    angle_t angle_x, angle_y, angle_z;
    angle_t step_x_r, step_y_r, step_z_r;
    logic   freeze_r;

    angle_t wrap_x, wrap_y, wrap_z;
    logic   bad_x, bad_y, bad_z;

    angle_wrap_add u_wrap_x (.angle(angle_x), .step(step_x_r), .wrapped(wrap_x), .step_bad(bad_x));
    angle_wrap_add u_wrap_y (.angle(angle_y), .step(step_y_r), .wrapped(wrap_y), .step_bad(bad_y));
    angle_wrap_add u_wrap_z (.angle(angle_z), .step(step_z_r), .wrapped(wrap_z), .step_bad(bad_z));

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state       <= IDLE;
            angle_x     <= '0;
            angle_y     <= '0;
            angle_z     <= '0;
            step_x_r    <= '0;
            step_y_r    <= '0;
            step_z_r    <= '0;
            freeze_r    <= 1'b0;
            angle_out   <= '0;
            axis_id     <= AXIS_X;
            angle_valid <= 1'b0;
            frame_done  <= 1'b0;
            busy        <= 1'b0;
            overrun     <= 1'b0;
            step_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // clear takes priority over a coincident frame_start
                    if (clear) begin
                        angle_x  <= '0;
                        angle_y  <= '0;
                        angle_z  <= '0;
                        overrun  <= 1'b0;
                        step_err <= 1'b0;
                    end else if (frame_start) begin
                        step_x_r <= step_x;
                        step_y_r <= step_y;
                        step_z_r <= step_z;
                        freeze_r <= freeze;
                        busy     <= 1'b1;
                        state    <= UPDATE;
                    end
                end
                UPDATE: begin
                    if (!freeze_r) begin
                        angle_x <= wrap_x;
                        angle_y <= wrap_y;
                        angle_z <= wrap_z;
                    end
                    step_err    <= step_err | bad_x | bad_y | bad_z;
                    angle_out   <= freeze_r ? angle_x : wrap_x;
                    axis_id     <= AXIS_X;
                    angle_valid <= 1'b1;
                    state       <= SEND_X;
                end
                SEND_X: begin
                    if (angle_ready) begin
                        angle_out <= angle_y;
                        axis_id   <= AXIS_Y;
                        state     <= SEND_Y;
                    end
                end
                SEND_Y: begin
                    if (angle_ready) begin
                        angle_out <= angle_z;
                        axis_id   <= AXIS_Z;
                        state     <= SEND_Z;
                    end
                end
                SEND_Z: begin
                    if (angle_ready) begin
                        angle_valid <= 1'b0;
                        frame_done  <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    frame_done <= 1'b0;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (frame_start && state != IDLE) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rotation_angle_gen.sv
// Directed self-checking bench for rotation_angle_gen with hand-computed expected angles.
module tb_rotation_angle_gen;
    import rot_pkg::*;

    logic       Clk;
    logic       Reset_n;
    logic       frame_start;
    logic       freeze;
    logic       clear;
    angle_t     step_x, step_y, step_z;
    angle_t     angle_out;
    logic [1:0] axis_id;
    logic       angle_valid;
    logic       angle_ready;
    logic       frame_done;
    logic       busy;
    logic       overrun;
    logic       step_err;

    int pass_cnt  = 0;
    int total_cnt = 0;

    rotation_angle_gen dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .frame_start(frame_start),
        .freeze     (freeze),
        .clear      (clear),
        .step_x     (step_x),
        .step_y     (step_y),
        .step_z     (step_z),
        .angle_out  (angle_out),
        .axis_id    (axis_id),
        .angle_valid(angle_valid),
        .angle_ready(angle_ready),
        .frame_done (frame_done),
        .busy       (busy),
        .overrun    (overrun),
        .step_err   (step_err)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    // Runs one frame with ready held high, collecting the transferred angle for each axis.
    task automatic run_frame(input string tag, input angle_t sx, input angle_t sy, input angle_t sz,
                             input logic frz, output angle_t ax, output angle_t ay, output angle_t az);
        logic done_seen;
        ax = '0;
        ay = '0;
        az = '0;
        done_seen = 1'b0;
        step_x = sx;
        step_y = sy;
        step_z = sz;
        freeze = frz;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        freeze = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (angle_valid && angle_ready) begin
                case (axis_id)
                    AXIS_X:  ax = angle_out;
                    AXIS_Y:  ay = angle_out;
                    default: az = angle_out;
                endcase
            end
            if (frame_done) begin
                done_seen = 1'b1;
                break;
            end
            tick();
        end
        check({tag, "_done"}, 32'(done_seen), 32'd1);
        tick();
    endtask

    angle_t ax, ay, az;

    initial begin
        Reset_n     = 1'b0;
        frame_start = 1'b0;
        freeze      = 1'b0;
        clear       = 1'b0;
        step_x      = '0;
        step_y      = '0;
        step_z      = '0;
        angle_ready = 1'b1;
        #1;
        check("rst_angle_out", 32'(angle_out), 32'h0);
        check("rst_axis_id", 32'(axis_id), 32'h0);
        check("rst_valid", 32'(angle_valid), 32'h0);
        check("rst_done", 32'(frame_done), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_overrun", 32'(overrun), 32'h0);
        check("rst_step_err", 32'(step_err), 32'h0);
        tick();
        tick();
        Reset_n = 1'b1;
        tick();

        // Basic: cycle-exact latency and ordering
        step_x = 12'h010;
        step_y = 12'h020;
        step_z = 12'h030;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("c1_busy", 32'(busy), 32'h1);
        check("c1_valid", 32'(angle_valid), 32'h0);
        tick();
        check("c2_valid", 32'(angle_valid), 32'h1);
        check("c2_axis", 32'(axis_id), 32'h0);
        check("c2_angle", 32'(angle_out), 32'h010);
        tick();
        check("c3_axis", 32'(axis_id), 32'h1);
        check("c3_angle", 32'(angle_out), 32'h020);
        tick();
        check("c4_axis", 32'(axis_id), 32'h2);
        check("c4_angle", 32'(angle_out), 32'h030);
        tick();
        check("c5_done", 32'(frame_done), 32'h1);
        check("c5_valid", 32'(angle_valid), 32'h0);
        tick();
        check("c6_busy", 32'(busy), 32'h0);
        check("c6_done", 32'(frame_done), 32'h0);

        // Positive wrap: walk X up to 0x640, then past 2pi
        do_clear();
        for (int i = 0; i < 100; i++) begin
            run_frame("preload", 12'h010, 12'h000, 12'h000, 1'b0, ax, ay, az);
        end
        check("preload_x", 32'(ax), 32'h640);
        run_frame("poswrap", 12'h010, 12'h000, 12'h000, 1'b0, ax, ay, az);
        check("poswrap_x", 32'(ax), 32'h008);
        check("poswrap_err", 32'(step_err), 32'h0);

        // Negative wrap, bad steps and the -(2pi - 1) boundary
        do_clear();
        run_frame("negwrap", 12'h000, 12'hFF0, 12'h000, 1'b0, ax, ay, az);
        check("negwrap_y", 32'(ay), 32'h638);
        check("negwrap_err", 32'(step_err), 32'h0);
        run_frame("badstep", 12'h800, 12'h9B9, 12'h700, 1'b0, ax, ay, az);
        check("badstep_x", 32'(ax), 32'h000);
        check("edge_y", 32'(ay), 32'h639);
        check("badstep_z", 32'(az), 32'h000);
        check("badstep_err", 32'(step_err), 32'h1);
        do_clear();
        check("clear_err", 32'(step_err), 32'h0);

        // Backpressure during SEND_Y
        step_x = 12'h100;
        step_y = 12'h200;
        step_z = 12'h300;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
        check("bp_x", 32'(angle_out), 32'h100);
        tick();
        check("bp_y_axis", 32'(axis_id), 32'h1);
        angle_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_hold_valid", 32'(angle_valid), 32'h1);
            check("bp_hold_axis", 32'(axis_id), 32'h1);
            check("bp_hold_angle", 32'(angle_out), 32'h200);
        end
        angle_ready = 1'b1;
        tick();
        check("bp_z_axis", 32'(axis_id), 32'h2);
        check("bp_z_angle", 32'(angle_out), 32'h300);
        tick();
        check("bp_done", 32'(frame_done), 32'h1);
        tick();

        // clear together with frame_start: clear wins, nothing starts
        clear = 1'b1;
        frame_start = 1'b1;
        tick();
        clear = 1'b0;
        frame_start = 1'b0;
        check("clr_fs_busy", 32'(busy), 32'h0);
        check("clr_fs_overrun", 32'(overrun), 32'h0);
        tick();
        check("clr_fs_busy2", 32'(busy), 32'h0);

        // Overrun: frame_start during SEND_X does not disturb the frame
        step_x = 12'h010;
        step_y = 12'h020;
        step_z = 12'h030;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
        check("ovr_x", 32'(angle_out), 32'h010);
        step_x = 12'h100;
        step_y = 12'h100;
        step_z = 12'h100;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("ovr_flag", 32'(overrun), 32'h1);
        check("ovr_y", 32'(angle_out), 32'h020);
        tick();
        check("ovr_z", 32'(angle_out), 32'h030);
        tick();
        tick();
        check("ovr_idle", 32'(busy), 32'h0);

        // Freeze: angles resent unchanged despite a nonzero step
        run_frame("freeze", 12'h100, 12'h100, 12'h100, 1'b1, ax, ay, az);
        check("freeze_x", 32'(ax), 32'h010);
        check("freeze_y", 32'(ay), 32'h020);
        check("freeze_z", 32'(az), 32'h030);
        check("ovr_sticky", 32'(overrun), 32'h1);
        do_clear();
        check("ovr_cleared", 32'(overrun), 32'h0);

        // Reset mid-send
        step_x = 12'h010;
        step_y = 12'h010;
        step_z = 12'h010;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
        tick();
        check("mid_axis", 32'(axis_id), 32'h1);
        Reset_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(angle_valid), 32'h0);
        check("mid_rst_angle", 32'(angle_out), 32'h0);
        check("mid_rst_axis", 32'(axis_id), 32'h0);
        check("mid_rst_busy", 32'(busy), 32'h0);
        #2;
        Reset_n = 1'b1;
        tick();
        check("mid_no_done", 32'(frame_done), 32'h0);
        tick();
        check("mid_no_done2", 32'(frame_done), 32'h0);
        run_frame("after_rst", 12'h010, 12'h010, 12'h010, 1'b0, ax, ay, az);
        check("after_rst_x", 32'(ax), 32'h010);
        check("after_rst_y", 32'(ay), 32'h010);
        check("after_rst_z", 32'(az), 32'h010);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
